// File: rtl/data_cache_if.sv
// CPU-side and RAM-side signal bundle of the direct-mapped data cache.
// DATACACHE_STATS_EN adds the three statistics counter outputs.
interface data_cache_if #(
    parameter int WORDS_PER_LINE = 4
);
    logic [31:0]                  iaddr;
    logic [31:0]                  idata_write;
    logic                         iSigMemRead;
    logic                         iSigMemWrite;
    logic                         ohit;
    logic [31:0]                  odata_read;
    logic [31:0]                  omem_addr;
    logic [31:0]                  omem_write_data;
    logic                         omem_read_req;
    logic                         omem_write_req;
    logic                         imem_ack;
    logic [WORDS_PER_LINE*32-1:0] imem_in;
`ifdef DATACACHE_STATS_EN
    logic [31:0]                  ostat_reads;
    logic [31:0]                  ostat_misses;
    logic [31:0]                  ostat_writes;

    modport master (
        output iaddr, idata_write, iSigMemRead, iSigMemWrite, imem_ack, imem_in,
        input  ohit, odata_read, omem_addr, omem_write_data, omem_read_req, omem_write_req,
        input  ostat_reads, ostat_misses, ostat_writes
    );
    modport slave (
        input  iaddr, idata_write, iSigMemRead, iSigMemWrite, imem_ack, imem_in,
        output ohit, odata_read, omem_addr, omem_write_data, omem_read_req, omem_write_req,
        output ostat_reads, ostat_misses, ostat_writes
    );
`else
    modport master (
        output iaddr, idata_write, iSigMemRead, iSigMemWrite, imem_ack, imem_in,
        input  ohit, odata_read, omem_addr, omem_write_data, omem_read_req, omem_write_req
    );
    modport slave (
        input  iaddr, idata_write, iSigMemRead, iSigMemWrite, imem_ack, imem_in,
        output ohit, odata_read, omem_addr, omem_write_data, omem_read_req, omem_write_req
    );
`endif
endinterface

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with req/ack RAM handshake.
// Optional DATACACHE_STATS_EN adds registered read/miss/write counters.
//
// state | meaning
// IDLE  | accept request; read hits complete here with no stall
// FILL  | line fill requested, waiting for imem_ack
// WRITE | write-through requested, waiting for imem_ack
// DONE  | access completes (ohit=1), then back to IDLE
module data_cache_ctrl #(
    parameter int LINES          = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input logic        clk,
    input logic        rst,
    data_cache_if.slave bus
);
    localparam int WSEL = $clog2(WORDS_PER_LINE);
    localparam int OFF  = WSEL + 2;
    localparam int IDX  = $clog2(LINES);
    localparam int TAG  = 32 - IDX - OFF;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0] valid;
    logic [TAG-1:0]   tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS_PER_LINE];

    logic [WSEL-1:0] wsel;
    logic [IDX-1:0]  idx;
    logic [TAG-1:0]  tag;
    logic            hit;
    logic            unused_bits;

    logic [31:0] mem_addr, mem_addr_nxt;
    logic [31:0] mem_wdata, mem_wdata_nxt;
    logic        rreq, rreq_nxt;
    logic        wreq, wreq_nxt;
    logic        ohit_c;
    logic        fill_we;
    logic        word_we;

    assign wsel        = bus.iaddr[OFF-1:2];
    assign idx         = bus.iaddr[OFF+IDX-1:OFF];
    assign tag         = bus.iaddr[31:OFF+IDX];
    assign unused_bits = ^bus.iaddr[1:0];
    assign hit         = valid[idx] && (tag_mem[idx] == tag);

    always_comb begin
        state_nxt     = state;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rreq_nxt      = rreq;
        wreq_nxt      = wreq;
        ohit_c        = 1'b0;
        fill_we       = 1'b0;
        word_we       = 1'b0;
        case (state)
            IDLE: begin
                // a simultaneous read+write is treated as a write
                if (bus.iSigMemWrite) begin
                    mem_addr_nxt  = bus.iaddr;
                    mem_wdata_nxt = bus.idata_write;
                    wreq_nxt      = 1'b1;
                    word_we       = hit;
                    state_nxt     = WRITE;
                end else if (bus.iSigMemRead) begin
                    if (hit) begin
                        ohit_c = 1'b1;
                    end else begin
                        mem_addr_nxt = {bus.iaddr[31:OFF], {OFF{1'b0}}};
                        rreq_nxt     = 1'b1;
                        state_nxt    = FILL;
                    end
                end else begin
                    ohit_c = 1'b1;
                end
            end
            FILL: begin
                if (bus.imem_ack) begin
                    fill_we   = 1'b1;
                    rreq_nxt  = 1'b0;
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                if (bus.imem_ack) begin
                    wreq_nxt  = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ohit_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rreq      <= 1'b0;
            wreq      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            rreq      <= rreq_nxt;
            wreq      <= wreq_nxt;
            if (fill_we) valid[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst && fill_we) begin
            tag_mem[idx] <= tag;
            for (int k = 0; k < WORDS_PER_LINE; k++)
                data_mem[idx][k] <= bus.imem_in[32*k +: 32];
        end
        if (!rst && word_we) data_mem[idx][wsel] <= bus.idata_write;
    end

    assign bus.ohit            = ohit_c;
    assign bus.odata_read      = data_mem[idx][wsel];
    assign bus.omem_addr       = mem_addr;
    assign bus.omem_write_data = mem_wdata;
    assign bus.omem_read_req   = rreq;
    assign bus.omem_write_req  = wreq;

`ifdef DATACACHE_STATS_EN
    logic [31:0] stat_reads, stat_misses, stat_writes;
    logic        rd_done, miss_start, wr_start;

    // ohit with a read-only request means a load completes this cycle (IDLE hit or DONE)
    assign rd_done    = ohit_c && bus.iSigMemRead && !bus.iSigMemWrite;
    assign miss_start = (state == IDLE) && (state_nxt == FILL);
    assign wr_start   = (state == IDLE) && (state_nxt == WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads  <= '0;
            stat_misses <= '0;
            stat_writes <= '0;
        end else begin
            if (rd_done)    stat_reads  <= stat_reads + 32'd1;
            if (miss_start) stat_misses <= stat_misses + 32'd1;
            if (wr_start)   stat_writes <= stat_writes + 32'd1;
        end
    end

    assign bus.ostat_reads  = stat_reads;
    assign bus.ostat_misses = stat_misses;
    assign bus.ostat_writes = stat_writes;
`endif
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: directed scenarios plus randomized traffic
// checked against a coherent-RAM model (loads always return RAM contents).
module tb_data_cache_ctrl;
    localparam int LINES      = 4;
    localparam int WPL        = 4;
    localparam int LINE_BYTES = WPL * 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    logic        m_valid [LINES];
    logic [31:0] m_base  [LINES];
    logic [31:0] ram     [logic [31:0]];
`ifdef DATACACHE_STATS_EN
    int e_reads, e_misses, e_writes;
`endif

    data_cache_if #(.WORDS_PER_LINE(WPL)) bus ();

    data_cache_ctrl #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (ram.exists(w)) return ram[w];
        return (w * 32'h0001_0003) ^ 32'h5A5A_1234;
    endfunction

    task automatic idle_inputs();
        bus.iSigMemRead  = 1'b0;
        bus.iSigMemWrite = 1'b0;
        bus.imem_ack     = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
`ifdef DATACACHE_STATS_EN
        e_reads = 0; e_misses = 0; e_writes = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // Starts and ends on a negedge; expectations come from the model and ram.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, input string name);
        logic [31:0] base;
        int          idx;
        logic        hit;
        logic [1:0]  ereq;
        base = addr & ~32'(LINE_BYTES - 1);
        idx  = int'((addr / LINE_BYTES) % LINES);
        hit  = m_valid[idx] && (m_base[idx] == base);
        bus.iaddr        = addr;
        bus.idata_write  = wdata;
        bus.iSigMemRead  = rd;
        bus.iSigMemWrite = wr;
        #1;
        if (rd && !wr && hit) begin
            n_cmp++;
            if (bus.ohit !== 1'b1 || bus.odata_read !== ram_rd(addr)) begin
                n_fail++;
                $display("FAIL %s hit: ohit=%b data=%h, want ohit=1 data=%h", name, bus.ohit, bus.odata_read, ram_rd(addr));
            end
`ifdef DATACACHE_STATS_EN
            e_reads++;
`endif
            @(negedge clk);
            n_cmp++;
            if ({bus.omem_read_req, bus.omem_write_req} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s hit_noreq: req=%b%b want 00", name, bus.omem_read_req, bus.omem_write_req);
            end
        end else begin
            n_cmp++;
            if (bus.ohit !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall: ohit=%b want 0", name, bus.ohit);
            end
            ereq = wr ? 2'b01 : 2'b10;
            if (wr) begin
                ram[{addr[31:2], 2'b00}] = wdata;
`ifdef DATACACHE_STATS_EN
                e_writes++;
`endif
            end else begin
`ifdef DATACACHE_STATS_EN
                e_misses++;
`endif
            end
            @(negedge clk);
            n_cmp++;
            if ({bus.omem_read_req, bus.omem_write_req} !== ereq ||
                bus.omem_addr !== (wr ? addr : base) ||
                (wr && bus.omem_write_data !== wdata)) begin
                n_fail++;
                $display("FAIL %s issue: req=%b%b addr=%h wd=%h, want req=%b addr=%h wd=%h", name,
                         bus.omem_read_req, bus.omem_write_req, bus.omem_addr, bus.omem_write_data,
                         ereq, (wr ? addr : base), wdata);
            end
            for (int i = 1; i < delay; i++) begin
                @(negedge clk);
                n_cmp++;
                if ({bus.ohit, bus.omem_read_req, bus.omem_write_req} !== {1'b0, ereq}) begin
                    n_fail++;
                    $display("FAIL %s wait: ohit/req=%b%b%b want 0%b", name, bus.ohit,
                             bus.omem_read_req, bus.omem_write_req, ereq);
                end
            end
            bus.imem_ack = 1'b1;
            for (int k = 0; k < WPL; k++) bus.imem_in[32*k +: 32] = ram_rd(base + 32'(4 * k));
            @(negedge clk);
            bus.imem_ack = 1'b0;
            #1;
            n_cmp++;
            if ({bus.ohit, bus.omem_read_req, bus.omem_write_req} !== 3'b100) begin
                n_fail++;
                $display("FAIL %s done: ohit/req=%b%b%b want 100", name, bus.ohit,
                         bus.omem_read_req, bus.omem_write_req);
            end
            if (rd && !wr) begin
                n_cmp++;
                if (bus.odata_read !== ram_rd(addr)) begin
                    n_fail++;
                    $display("FAIL %s fill_data: got %h want %h", name, bus.odata_read, ram_rd(addr));
                end
                m_valid[idx] = 1'b1;
                m_base[idx]  = base;
`ifdef DATACACHE_STATS_EN
                e_reads++;
`endif
            end
            @(negedge clk);
        end
        idle_inputs();
`ifdef DATACACHE_STATS_EN
        n_cmp++;
        if (bus.ostat_reads !== 32'(e_reads) || bus.ostat_misses !== 32'(e_misses) ||
            bus.ostat_writes !== 32'(e_writes)) begin
            n_fail++;
            $display("FAIL %s stats: r/m/w=%0d/%0d/%0d want %0d/%0d/%0d", name, bus.ostat_reads,
                     bus.ostat_misses, bus.ostat_writes, e_reads, e_misses, e_writes);
        end
`endif
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({bus.ohit, bus.omem_read_req, bus.omem_write_req} !== 3'b100 ||
            bus.omem_addr !== 32'h0 || bus.omem_write_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ohit/req=%b%b%b addr=%h wd=%h, want 100 0 0", bus.ohit,
                     bus.omem_read_req, bus.omem_write_req, bus.omem_addr, bus.omem_write_data);
        end
    endtask

    task automatic test_read_miss_fill();
        ram[32'h40] = 32'hA; ram[32'h44] = 32'hB; ram[32'h48] = 32'hC; ram[32'h4C] = 32'hD;
        access(1'b1, 1'b0, 32'h44, 32'h0, 3, "miss_0x44");
        access(1'b1, 1'b0, 32'h48, 32'h0, 1, "hit_0x48");
    endtask

    task automatic test_conflict();
        access(1'b1, 1'b0, 32'h140, 32'h0, 2, "conflict_0x140");
        access(1'b1, 1'b0, 32'h40, 32'h0, 1, "refill_0x40");
    endtask

    task automatic test_write_hit();
        access(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 2, "wr_hit_0x44");
        access(1'b1, 1'b0, 32'h44, 32'h0, 1, "rd_after_wr_0x44");
    endtask

    task automatic test_write_miss();
        access(1'b0, 1'b1, 32'h200, 32'h12345678, 1, "wr_miss_0x200");
        access(1'b1, 1'b0, 32'h200, 32'h0, 2, "rd_after_wrmiss_0x200");
    endtask

    task automatic test_reset_during_fill();
        bus.iaddr        = 32'h80;
        bus.iSigMemRead  = 1'b1;
        bus.iSigMemWrite = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.omem_read_req !== 1'b1 || bus.omem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL rstfill_issue: rreq=%b addr=%h want 1 00000080", bus.omem_read_req, bus.omem_addr);
        end
        @(negedge clk);
        bus.imem_ack = 1'b1;
        for (int k = 0; k < WPL; k++) bus.imem_in[32*k +: 32] = ram_rd(32'h80 + 32'(4 * k));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        clear_model();
        #1;
        n_cmp++;
        if ({bus.ohit, bus.omem_read_req, bus.omem_write_req} !== 3'b100 || bus.omem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstfill_abandon: ohit/req=%b%b%b addr=%h want 100 0", bus.ohit,
                     bus.omem_read_req, bus.omem_write_req, bus.omem_addr);
        end
        @(negedge clk);
        access(1'b1, 1'b0, 32'h80, 32'h0, 1, "rd_after_rst_0x80");
    endtask

    task automatic test_rd_wr_priority();
        do_reset();
        access(1'b1, 1'b1, 32'h44, 32'hCAFE0001, 2, "rdwr_0x44");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] tg, a;
            int op;
            tg = ($urandom_range(0, 3) == 3) ? 32'h03FF_FFFF : 32'($urandom_range(0, 2));
            a  = ((tg * LINES + 32'($urandom_range(0, LINES - 1))) * WPL + 32'($urandom_range(0, WPL - 1))) * 4;
            op = $urandom_range(0, 9);
            if (op < 6)      access(1'b1, 1'b0, a, 32'h0, $urandom_range(1, 4), "rand_rd");
            else if (op < 9) access(1'b0, 1'b1, a, $urandom, $urandom_range(1, 4), "rand_wr");
            else             access(1'b1, 1'b1, a, $urandom, $urandom_range(1, 4), "rand_rdwr");
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.iaddr       = 32'h0;
        bus.idata_write = 32'h0;
        bus.imem_in     = '0;
        idle_inputs();
        clear_model();
        @(negedge clk);
        test_reset();
        test_read_miss_fill();
        test_conflict();
        test_write_hit();
        test_write_miss();
        test_reset_during_fill();
        test_reset();
        test_rd_wr_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
